// File: rtl/seg7_pkg.sv
// Shared types, segment constants and range helper for the seven-segment
// display sequencer and its encoder.
package seg7_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Active-high segment patterns, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Largest decimal value that fits in num_digits digits (10^n - 1).
  function automatic int max_value(input int num_digits);
    int v;
    v = 1;
    for (int i = 0; i < num_digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Combinational BCD digit to seven-segment pattern encoder with dash and
// blank overrides and selectable output polarity.
module seg7_encoder
  import seg7_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_hi;

  // Choose the active-high pattern: dash beats blank, blank beats the digit.
  // Non-decimal nibbles never occur after conversion; show a dash if they do.
  always_comb begin
    seg_hi = SEG_BLANK;
    if (dash_i) begin
      seg_hi = SEG_DASH;
    end else if (blank_i) begin
      seg_hi = SEG_BLANK;
    end else if (digit_i <= 4'd9) begin
      seg_hi = SEG_DIGIT[digit_i];
    end else begin
      seg_hi = SEG_DASH;
    end
  end

  assign seg_o = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;

endmodule

// File: rtl/seg7_display_sequencer.sv
// Avalon-MM write master: takes a binary value, converts it to BCD with an
// iterative double-dabble, then writes one segment pattern per digit PIO,
// least-significant digit first.
//
// Input handshake: a value transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE; while busy the source
// must hold its value and in_valid is ignored.
module seg7_display_sequencer
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14,
  parameter int ACTIVE_LOW = 1,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VALUE_W-1:0]    in_value,
  output logic [NUM_DIGITS-1:0] pio_chipselect,
  output logic [1:0]            pio_address,
  output logic                  pio_write_n,
  output logic [31:0]           pio_writedata,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [1:0]            dbg_state
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + NUM_DIGITS + 1);
  localparam logic [VALUE_W-1:0] MAX_VAL = VALUE_W'(max_value(NUM_DIGITS));

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [VALUE_W-1:0]    val_q, val_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [BCD_W-1:0]      bcd_adj;
  logic                  ovf_q, ovf_d;
  logic [NUM_DIGITS-1:0] cs_q, cs_d;
  logic                  wn_q, wn_d;
  logic [31:0]           wd_q, wd_d;
  logic                  done_q, done_d;

  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  higher_zero;
  logic [3:0]            digit_sel;
  logic                  blank_sel;
  logic [6:0]            seg;

  // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // FSM next state plus conversion datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          val_d = in_value;
          bcd_d = '0;
          cnt_d = '0;
          if (in_value > MAX_VAL) begin
            // Out of range: no conversion, every digit shows a dash.
            ovf_d   = 1'b1;
            state_d = ST_WRITE;
          end else begin
            ovf_d   = 1'b0;
            state_d = ST_CONVERT;
          end
        end
      end
      ST_CONVERT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], val_q[VALUE_W-1]};
        val_d = {val_q[VALUE_W-2:0], 1'b0};
        if (cnt_q == CNT_W'(VALUE_W - 1)) begin
          cnt_d   = '0;
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Leading-zero map: digit k>0 blanks when it and every higher digit are zero.
  always_comb begin
    blank_vec   = '0;
    higher_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      higher_zero  = higher_zero && (bcd_d[4*k +: 4] == 4'd0);
      blank_vec[k] = (BLANK_LZ != 0) && (k != 0) && higher_zero;
    end
  end

  // Digit mux: select the digit that the next bus cycle will write.
  always_comb begin
    digit_sel = '0;
    blank_sel = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (cnt_d == CNT_W'(k)) begin
        digit_sel = bcd_d[4*k +: 4];
        blank_sel = blank_vec[k];
      end
    end
  end

  seg7_encoder #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_encoder (
    .digit_i(digit_sel),
    .blank_i(blank_sel),
    .dash_i (ovf_d),
    .seg_o  (seg)
  );

  // Bus outputs are decoded from the next state and registered, so they line
  // up with the state register and cannot glitch.
  always_comb begin
    cs_d   = '0;
    wn_d   = 1'b1;
    wd_d   = '0;
    done_d = (state_d == ST_DONE);
    if (state_d == ST_WRITE) begin
      cs_d = NUM_DIGITS'(1) << cnt_d;
      wn_d = 1'b0;
      wd_d = {25'b0, seg};
    end
  end

  // State, datapath and output registers; reset drops strobes immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cs_q    <= '0;
      wn_q    <= 1'b1;
      wd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
    end
  end

  assign in_ready       = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign overflow       = ovf_q;
  assign pio_chipselect = cs_q;
  assign pio_address    = 2'b00;
  assign pio_write_n    = wn_q;
  assign pio_writedata  = wd_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_seg7_display_sequencer.sv
// Bench for seg7_display_sequencer: a BLANK_LZ=1 and a BLANK_LZ=0 instance
// share one input stream; a scoreboard of timed expected writes is filled by
// the driver and drained by a negedge monitor.
module tb_seg7_display_sequencer;

  localparam int NUM_DIGITS = 4;
  localparam int VALUE_W    = 14;
  localparam int MAX_V      = 9999;

  localparam logic [6:0] LO_PAT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  cs;
    logic [6:0]  seg_a;
    logic [6:0]  seg_b;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n;
  logic in_valid;
  logic [VALUE_W-1:0] in_value;

  logic a_in_ready, a_wn, a_busy, a_done, a_ovf;
  logic [3:0] a_cs;
  logic [1:0] a_addr, a_dbg;
  logic [31:0] a_wd;
  logic b_in_ready, b_wn, b_busy, b_done, b_ovf;
  logic [3:0] b_cs;
  logic [1:0] b_addr, b_dbg;
  logic [31:0] b_wd;

  wr_t exp_q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int last_acc = -100;
  int last_done = -100;
  logic last_ovf = 1'b0;
  logic prev_ovf = 1'b0;
  logic [6:0] pio_mem [4];
  logic [6:0] pio_model [4];
  logic m_busy;
  wr_t m_e;

  seg7_display_sequencer #(
    .NUM_DIGITS(NUM_DIGITS), .VALUE_W(VALUE_W), .ACTIVE_LOW(1), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_value(in_value), .pio_chipselect(a_cs), .pio_address(a_addr),
    .pio_write_n(a_wn), .pio_writedata(a_wd), .busy(a_busy), .done(a_done),
    .overflow(a_ovf), .dbg_state(a_dbg)
  );

  seg7_display_sequencer #(
    .NUM_DIGITS(NUM_DIGITS), .VALUE_W(VALUE_W), .ACTIVE_LOW(1), .BLANK_LZ(0)
  ) dut_nlz (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_value(in_value), .pio_chipselect(b_cs), .pio_address(b_addr),
    .pio_write_n(b_wn), .pio_writedata(b_wd), .busy(b_busy), .done(b_done),
    .overflow(b_ovf), .dbg_state(b_dbg)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference: the pattern digit k of value v should show.
  function automatic logic [6:0] exp_seg(input int v, input int k, input bit blz);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (v > MAX_V) return 7'h3F;
    if (blz && (k > 0) && (v < p)) return 7'h7F;
    return LO_PAT[(v / p) % 10];
  endfunction

  // Push the timed write sequence for a value accepted at edge t.
  task automatic push_expected(input int v, input int t);
    wr_t e;
    int base;
    base = (v > MAX_V) ? t : t + VALUE_W;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      e.cyc   = 32'(base + k);
      e.cs    = 4'(1 << k);
      e.seg_a = exp_seg(v, k, 1'b1);
      e.seg_b = exp_seg(v, k, 1'b0);
      exp_q.push_back(e);
    end
    prev_ovf  = last_ovf;
    last_ovf  = (v > MAX_V);
    last_acc  = t;
    last_done = base + NUM_DIGITS;
  endtask

  // Driver: called at a negedge; offers v until accepted.
  task automatic send(input int v, input bit keep);
    int waited;
    waited = 0;
    in_value = 14'(v);
    in_valid = 1'b1;
    while (!a_in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_wait", a_in_ready, 1);
    if (a_in_ready) push_expected(v, cyc + 1);
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic reset_now();
    reset_n = 1'b0;
    exp_q.delete();
    last_acc  = -100;
    last_done = -100;
    last_ovf  = 1'b0;
    prev_ovf  = 1'b0;
  endtask

  // PIO slave model: capture every accepted write.
  always @(posedge clk) begin
    if (reset_n && !a_wn) begin
      for (int k = 0; k < 4; k++) begin
        if (a_cs[k]) pio_mem[k] <= a_wd[6:0];
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      m_busy = (cyc >= last_acc) && (cyc <= last_done);
      check("busy", a_busy, m_busy);
      check("in_ready", a_in_ready, !m_busy);
      check("done", a_done, cyc == last_done);
      check("overflow", a_ovf, (cyc >= last_acc) ? last_ovf : prev_ovf);
      check("address", a_addr, 0);
      if (exp_q.size() != 0 && exp_q[0].cyc == 32'(cyc)) begin
        m_e = exp_q.pop_front();
        check("wr_n", a_wn, 0);
        check("wr_cs", a_cs, m_e.cs);
        check("wr_data", a_wd, {25'b0, m_e.seg_a});
        check("wr_n_nlz", b_wn, 0);
        check("wr_data_nlz", b_wd, {25'b0, m_e.seg_b});
        for (int k = 0; k < 4; k++) begin
          if (m_e.cs[k]) pio_model[k] = m_e.seg_a;
        end
      end else begin
        check("idle_wr_n", a_wn, 1);
        check("idle_cs", a_cs, 0);
        check("idle_wr_n_nlz", b_wn, 1);
      end
    end
  end

  // Stimulus.
  initial begin
    int v;
    int guard;
    for (int k = 0; k < 4; k++) begin
      pio_mem[k]   = 7'h55;
      pio_model[k] = 7'h55;
    end
    in_valid = 1'b0;
    in_value = '0;
    reset_n  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_cs", a_cs, 0);
    check("rst_addr", a_addr, 0);
    check("rst_wn", a_wn, 1);
    check("rst_wd", a_wd, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_ovf", a_ovf, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed values, including range boundaries.
    send(1234, 0);
    send(42, 0);
    send(0, 0);
    send(9999, 0);
    send(12000, 0);
    send(5, 0);
    send(10000, 0);
    send(16383, 0);
    send(7, 0);

    // in_valid held through the busy window with a different value.
    send(777, 1);
    in_value = 14'(3210);
    send(3210, 0);

    // Random values, biased toward the range boundary.
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) v = $urandom_range(9990, 10010);
      else v = $urandom_range(0, 16383);
      send(v, 0);
    end

    // Reset after the second write of 8888.
    send(1234, 0);
    send(8888, 0);
    guard = 0;
    while (cyc < last_acc + VALUE_W + 1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    reset_now();
    #1;
    check("midrst_cs", a_cs, 0);
    check("midrst_wn", a_wn, 1);
    check("midrst_busy", a_busy, 0);
    check("midrst_in_ready", a_in_ready, 1);
    for (int k = 0; k < 4; k++) check("midrst_pio", pio_mem[k], pio_model[k]);
    check("midrst_pio0", pio_mem[0], exp_seg(8888, 0, 1'b1));
    check("midrst_pio3", pio_mem[3], exp_seg(1234, 3, 1'b1));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", a_in_ready, 1);
    send(56, 0);

    // Drain the scoreboard.
    guard = 0;
    while ((exp_q.size() != 0 || cyc <= last_done) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
    for (int k = 0; k < 4; k++) check("final_pio", pio_mem[k], pio_model[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
